// File: rtl/shift_rows_stream.sv
// Streaming AES ShiftRows/InvShiftRows stage with a two-bank ping-pong block buffer.
// Build option: define SHIFTROWS_INV_EN to honour s_inv; otherwise forward ShiftRows only.
module shift_rows_stream #(
    parameter int unsigned LANES = 1,
    parameter int unsigned CNT_W = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               s_valid,
    output logic               s_ready,
    input  logic [8*LANES-1:0] s_data,
    input  logic               s_inv,
    output logic               m_valid,
    input  logic               m_ready,
    output logic [8*LANES-1:0] m_data,
    output logic               m_last,
    output logic [CNT_W-1:0]   blk_cnt
);
    localparam int unsigned Beats = 16 / LANES;
    localparam int unsigned BeatW = (Beats > 1) ? $clog2(Beats) : 1;
    localparam logic [BeatW-1:0] LastBeat = BeatW'(Beats - 1);

    logic [1:0]       full;
    logic             wsel;
    logic             rsel;
    logic [BeatW-1:0] wbeat;
    logic [BeatW-1:0] rbeat;
    logic [CNT_W-1:0] cnt;
    logic [7:0]       mem [2][16];
    logic             wr_fire;
    logic             rd_fire;

    // Outputs are gated by rst_n so they read as idle for the whole reset window.
    assign s_ready = rst_n & ~full[wsel];
    assign m_valid = rst_n & full[rsel];
    assign m_last  = m_valid & (rbeat == LastBeat);
    assign blk_cnt = rst_n ? cnt : '0;
    assign wr_fire = s_valid & s_ready;
    assign rd_fire = m_valid & m_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            full  <= '0;
            wsel  <= 1'b0;
            rsel  <= 1'b0;
            wbeat <= '0;
            rbeat <= '0;
            cnt   <= '0;
        end else begin
            if (wr_fire) begin
                if (wbeat == LastBeat) begin
                    full[wsel] <= 1'b1;
                    wsel       <= ~wsel;
                    wbeat      <= '0;
                end else begin
                    wbeat <= wbeat + BeatW'(1);
                end
            end
            // A write can only target an empty bank and a read a full one, so the two
            // full-flag updates below never collide on the same bank.
            if (rd_fire) begin
                if (rbeat == LastBeat) begin
                    full[rsel] <= 1'b0;
                    rsel       <= ~rsel;
                    rbeat      <= '0;
                    cnt        <= cnt + CNT_W'(1);
                end else begin
                    rbeat <= rbeat + BeatW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (wr_fire) begin
            for (int k = 0; k < int'(LANES); k++) begin
                mem[wsel][4'(int'(wbeat) * int'(LANES) + k)] <= s_data[8*k +: 8];
            end
        end
    end

`ifdef SHIFTROWS_INV_EN
    logic [1:0] mode;

    always_ff @(posedge clk) begin
        if (wr_fire && (wbeat == '0)) begin
            mode[wsel] <= s_inv;
        end
    end
`else
    logic unused_inv;
    assign unused_inv = s_inv;
`endif

    // Output byte n = 4c + r pulls state byte {col, r} with col = c +/- r (mod 4).
    logic [3:0] n;
    logic [3:0] src;
    logic [1:0] c;
    logic [1:0] r;

    always_comb begin
        m_data = '0;
        n      = '0;
        src    = '0;
        c      = '0;
        r      = '0;
        if (m_valid) begin
            for (int k = 0; k < int'(LANES); k++) begin
                n = 4'(int'(rbeat) * int'(LANES) + k);
                c = n[3:2];
                r = n[1:0];
`ifdef SHIFTROWS_INV_EN
                src = mode[rsel] ? {2'(c - r), r} : {2'(c + r), r};
`else
                src = {2'(c + r), r};
`endif
                m_data[8*k +: 8] = mem[rsel][src];
            end
        end
    end

endmodule

// File: tb/tb_shift_rows_stream.sv
// Self-checking bench for shift_rows_stream: a LANES=1/CNT_W=2 instance and a LANES=4 instance,
// checked against a column/row ShiftRows model.
module tb_shift_rows_stream;
    logic clk = 1'b0;
    always #5 clk = ~clk;

`ifdef SHIFTROWS_INV_EN
    localparam bit InvEn = 1'b1;
`else
    localparam bit InvEn = 1'b0;
`endif

    localparam logic [127:0] SeqBlk = 128'h0f0e0d0c_0b0a0908_07060504_03020100;
    localparam logic [127:0] FwdSeq = 128'h0b06010c_07020d08_030e0904_0f0a0500;
    localparam logic [127:0] InvSeq = 128'h0306090c_0f020508_0b0e0104_070a0d00;

    logic        rst1, sv1, sr1, si1, mv1, mr1, ml1;
    logic [7:0]  sd1, md1;
    logic [1:0]  bc1;
    logic        rst4, sv4, sr4, si4, mv4, mr4, ml4;
    logic [31:0] sd4, md4;
    logic [7:0]  bc4;

    int checks = 0;
    int errors = 0;

    shift_rows_stream #(.LANES(1), .CNT_W(2)) u_l1 (
        .clk(clk), .rst_n(rst1), .s_valid(sv1), .s_ready(sr1), .s_data(sd1), .s_inv(si1),
        .m_valid(mv1), .m_ready(mr1), .m_data(md1), .m_last(ml1), .blk_cnt(bc1)
    );

    shift_rows_stream #(.LANES(4), .CNT_W(8)) u_l4 (
        .clk(clk), .rst_n(rst4), .s_valid(sv4), .s_ready(sr4), .s_data(sd4), .s_inv(si4),
        .m_valid(mv4), .m_ready(mr4), .m_data(md4), .m_last(ml4), .blk_cnt(bc4)
    );

    // State byte 4c+r; forward row r rotates left by r columns, inverse rotates right.
    function automatic logic [127:0] ref_perm(input logic [127:0] blk, input bit inv);
        logic [127:0] o;
        int sc;
        o = '0;
        for (int col = 0; col < 4; col++) begin
            for (int row = 0; row < 4; row++) begin
                sc = inv ? (col - row + 4) % 4 : (col + row) % 4;
                o[8*(4*col+row) +: 8] = blk[8*(4*sc+row) +: 8];
            end
        end
        return o;
    endfunction

    function automatic logic [127:0] rand_blk();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    // s_inv is driven inverted on non-first beats so a mode taken from them is visible.
    task automatic drive1(input logic [127:0] blk, input bit inv, output bit ok);
        int w;
        ok = 1'b1;
        for (int b = 0; b < 16; b++) begin
            sv1 = 1'b1;
            sd1 = blk[8*b +: 8];
            si1 = (b == 0) ? inv : ~inv;
            w = 0;
            while (sr1 !== 1'b1 && w < 300) begin
                @(negedge clk);
                w++;
            end
            if (w >= 300) begin
                ok = 1'b0;
                sv1 = 1'b0;
                return;
            end
            @(negedge clk);
        end
        sv1 = 1'b0;
    endtask

    task automatic collect1(output logic [127:0] got, output bit last_ok, output bit ok);
        int w;
        got = '0;
        ok = 1'b1;
        last_ok = 1'b1;
        mr1 = 1'b1;
        for (int b = 0; b < 16; b++) begin
            w = 0;
            while (mv1 !== 1'b1 && w < 300) begin
                @(negedge clk);
                w++;
            end
            if (w >= 300) begin
                ok = 1'b0;
                mr1 = 1'b0;
                return;
            end
            got[8*b +: 8] = md1;
            if (ml1 !== (b == 15)) last_ok = 1'b0;
            @(negedge clk);
        end
        mr1 = 1'b0;
    endtask

    task automatic drive4(input logic [127:0] blk, input bit inv, input int pct,
                          output bit ok, output int stalls);
        int w;
        ok = 1'b1;
        stalls = 0;
        for (int b = 0; b < 4; b++) begin
            sd4 = blk[32*b +: 32];
            si4 = (b == 0) ? inv : ~inv;
            w = 0;
            forever begin
                sv4 = ($urandom_range(99) < pct);
                if (sv4 && sr4 === 1'b1) break;
                if (sv4) stalls++;
                if (w >= 300) begin
                    ok = 1'b0;
                    sv4 = 1'b0;
                    return;
                end
                @(negedge clk);
                w++;
            end
            @(negedge clk);
        end
        sv4 = 1'b0;
    endtask

    task automatic collect4(input int pct, output logic [127:0] got, output bit last_ok,
                            output bit ok, output int waits);
        int w;
        got = '0;
        ok = 1'b1;
        last_ok = 1'b1;
        waits = 0;
        for (int b = 0; b < 4; b++) begin
            w = 0;
            forever begin
                mr4 = ($urandom_range(99) < pct);
                if (mv4 === 1'b1 && mr4) break;
                waits++;
                if (w >= 300) begin
                    ok = 1'b0;
                    mr4 = 1'b0;
                    return;
                end
                @(negedge clk);
                w++;
            end
            got[32*b +: 32] = md4;
            if (ml4 !== (b == 3)) last_ok = 1'b0;
            @(negedge clk);
        end
        mr4 = 1'b0;
    endtask

    task automatic test_reset;
        rst1 = 1'b0; rst4 = 1'b0;
        sv1 = 1'b0; sv4 = 1'b0; mr1 = 1'b0; mr4 = 1'b0;
        sd1 = '0; sd4 = '0; si1 = 1'b0; si4 = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({sr1, mv1, ml1, md1, bc1} !== '0) begin
            errors++;
            $display("FAIL reset_outs_l1 got %h exp 0", {sr1, mv1, ml1, md1, bc1});
        end
        checks++;
        if ({sr4, mv4, ml4, md4, bc4} !== '0) begin
            errors++;
            $display("FAIL reset_outs_l4 got %h exp 0", {sr4, mv4, ml4, md4, bc4});
        end
        rst1 = 1'b1; rst4 = 1'b1;
        @(negedge clk);
        checks++;
        if ({sr1, mv1, sr4, mv4} !== 4'b1010) begin
            errors++;
            $display("FAIL post_reset_ready got %b exp 1010", {sr1, mv1, sr4, mv4});
        end
    endtask

    task automatic test_fwd_l1;
        bit ok, lok;
        logic [127:0] got;
        drive1(SeqBlk, 1'b0, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL fwd_l1_accept got timeout exp accepted"); end
        checks++;
        if (mv1 !== 1'b1) begin
            errors++;
            $display("FAIL fwd_l1_latency got m_valid=%b exp 1", mv1);
        end
        collect1(got, lok, ok);
        checks++;
        if (!ok || got !== FwdSeq) begin
            errors++;
            $display("FAIL fwd_l1_data got %h exp %h", got, FwdSeq);
        end
        checks++;
        if (!lok) begin errors++; $display("FAIL fwd_l1_last got misplaced exp beat 15"); end
        checks++;
        if (bc1 !== 2'd1 || mv1 !== 1'b0) begin
            errors++;
            $display("FAIL fwd_l1_cnt got cnt=%0d mv=%b exp cnt=1 mv=0", bc1, mv1);
        end
    endtask

    task automatic test_inv_l4;
        bit ok, ok2, lok;
        int st, wt;
        logic [127:0] got, exp;
        exp = InvEn ? InvSeq : FwdSeq;
        drive4(SeqBlk, 1'b1, 100, ok, st);
        collect4(100, got, lok, ok2, wt);
        checks++;
        if (!ok || !ok2 || got !== exp) begin
            errors++;
            $display("FAIL inv_l4_data got %h exp %h", got, exp);
        end
        checks++;
        if (!lok || bc4 !== 8'd1) begin
            errors++;
            $display("FAIL inv_l4_last_cnt got last_ok=%b cnt=%0d exp 1 1", lok, bc4);
        end
    endtask

    task automatic test_back_to_back;
        logic [127:0] blk [4];
        logic [127:0] got [4];
        bit inv [4], dok [4], cok [4], lok [4];
        int dst [4], wt [4];
        for (int i = 0; i < 4; i++) begin
            blk[i] = rand_blk();
            inv[i] = 1'($urandom_range(1));
        end
        fork
            begin
                for (int i = 0; i < 4; i++) drive4(blk[i], inv[i], 100, dok[i], dst[i]);
            end
            begin
                for (int j = 0; j < 4; j++) collect4(100, got[j], lok[j], cok[j], wt[j]);
            end
        join
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (!dok[i] || dst[i] !== 0) begin
                errors++;
                $display("FAIL b2b_ready blk %0d got stalls=%0d exp 0", i, dst[i]);
            end
            checks++;
            if (wt[i] !== ((i == 0) ? 4 : 0)) begin
                errors++;
                $display("FAIL b2b_timing blk %0d got waits=%0d exp %0d", i, wt[i],
                         (i == 0) ? 4 : 0);
            end
            checks++;
            if (!cok[i] || !lok[i] || got[i] !== ref_perm(blk[i], inv[i] & InvEn)) begin
                errors++;
                $display("FAIL b2b_data blk %0d got %h exp %h", i, got[i],
                         ref_perm(blk[i], inv[i] & InvEn));
            end
        end
        checks++;
        if (bc4 !== 8'd5) begin errors++; $display("FAIL b2b_cnt got %0d exp 5", bc4); end
    endtask

    task automatic test_backpressure;
        logic [127:0] blk [3];
        logic [127:0] got [3];
        logic [127:0] expa;
        bit inv [3], cok [3], lok [3];
        bit oka, okb, okc;
        int st, wt [3];
        for (int i = 0; i < 3; i++) begin
            blk[i] = rand_blk();
            inv[i] = 1'($urandom_range(1));
        end
        expa = ref_perm(blk[0], inv[0] & InvEn);
        mr4 = 1'b0;
        drive4(blk[0], inv[0], 100, oka, st);
        drive4(blk[1], inv[1], 100, okb, st);
        checks++;
        if (!oka || !okb) begin errors++; $display("FAIL bp_fill got timeout exp 2 blocks"); end
        sv4 = 1'b1;
        sd4 = blk[2][31:0];
        si4 = inv[2];
        for (int k = 0; k < 3; k++) begin
            checks++;
            if ({sr4, mv4, ml4, md4} !== {1'b0, 1'b1, 1'b0, expa[31:0]}) begin
                errors++;
                $display("FAIL bp_hold cyc %0d got rdy=%b v=%b l=%b d=%h exp 0 1 0 %h",
                         k, sr4, mv4, ml4, md4, expa[31:0]);
            end
            @(negedge clk);
        end
        fork
            drive4(blk[2], inv[2], 100, okc, st);
            begin
                for (int j = 0; j < 3; j++) collect4(100, got[j], lok[j], cok[j], wt[j]);
            end
        join
        checks++;
        if (!okc || st !== 4) begin
            errors++;
            $display("FAIL bp_release got ok=%b stalls=%0d exp 1 4", okc, st);
        end
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (!cok[i] || !lok[i] || got[i] !== ref_perm(blk[i], inv[i] & InvEn)) begin
                errors++;
                $display("FAIL bp_order blk %0d got %h exp %h", i, got[i],
                         ref_perm(blk[i], inv[i] & InvEn));
            end
        end
        checks++;
        if (bc4 !== 8'd8) begin errors++; $display("FAIL bp_cnt got %0d exp 8", bc4); end
    endtask

    task automatic test_random_l4;
        logic [127:0] blk [20];
        logic [127:0] got [20];
        bit inv [20], dok [20], cok [20], lok [20];
        int dst [20], wt [20];
        for (int i = 0; i < 20; i++) begin
            blk[i] = rand_blk();
            inv[i] = 1'($urandom_range(1));
        end
        fork
            begin
                for (int i = 0; i < 20; i++) drive4(blk[i], inv[i], 70, dok[i], dst[i]);
            end
            begin
                for (int j = 0; j < 20; j++) collect4(60, got[j], lok[j], cok[j], wt[j]);
            end
        join
        for (int i = 0; i < 20; i++) begin
            checks++;
            if (!dok[i] || !cok[i] || !lok[i] || got[i] !== ref_perm(blk[i], inv[i] & InvEn))
            begin
                errors++;
                $display("FAIL rand_l4 blk %0d got %h exp %h", i, got[i],
                         ref_perm(blk[i], inv[i] & InvEn));
            end
        end
        checks++;
        if (bc4 !== 8'd28) begin errors++; $display("FAIL rand_cnt got %0d exp 28", bc4); end
    endtask

    task automatic test_reset_mid;
        bit ok, lok;
        logic [127:0] got;
        mr1 = 1'b0;
        drive1(rand_blk(), 1'b0, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL rmid_fill got timeout exp accepted"); end
        for (int b = 0; b < 8; b++) begin
            sv1 = 1'b1;
            sd1 = 8'(b);
            si1 = 1'b0;
            @(negedge clk);
        end
        sv1 = 1'b0;
        rst1 = 1'b0;
        @(negedge clk);
        checks++;
        if ({sr1, mv1, ml1, md1, bc1} !== '0) begin
            errors++;
            $display("FAIL rmid_outs got %h exp 0", {sr1, mv1, ml1, md1, bc1});
        end
        rst1 = 1'b1;
        @(negedge clk);
        checks++;
        if ({sr1, mv1} !== 2'b10) begin
            errors++;
            $display("FAIL rmid_after got rdy/valid=%b exp 10", {sr1, mv1});
        end
        drive1(SeqBlk, 1'b0, ok);
        collect1(got, lok, ok);
        checks++;
        if (!ok || !lok || got !== FwdSeq) begin
            errors++;
            $display("FAIL rmid_data got %h exp %h", got, FwdSeq);
        end
        checks++;
        if (bc1 !== 2'd1) begin errors++; $display("FAIL rmid_cnt got %0d exp 1", bc1); end
    endtask

    task automatic test_wrap;
        bit ok, ok2, lok, inv;
        logic [127:0] blk, got;
        logic [1:0] expc;
        rst1 = 1'b0;
        @(negedge clk);
        rst1 = 1'b1;
        @(negedge clk);
        expc = 2'd0;
        for (int i = 0; i < 5; i++) begin
            blk = rand_blk();
            inv = 1'($urandom_range(1));
            drive1(blk, inv, ok);
            collect1(got, lok, ok2);
            expc = expc + 2'd1;
            checks++;
            if (!ok || !ok2 || !lok || got !== ref_perm(blk, inv & InvEn)) begin
                errors++;
                $display("FAIL wrap_data blk %0d got %h exp %h", i, got, ref_perm(blk, inv & InvEn));
            end
            checks++;
            if (bc1 !== expc) begin
                errors++;
                $display("FAIL wrap_cnt blk %0d got %0d exp %0d", i, bc1, expc);
            end
        end
    endtask

    initial begin
        test_reset();
        test_fwd_l1();
        test_inv_l4();
        test_back_to_back();
        test_backpressure();
        test_random_l4();
        test_reset_mid();
        test_wrap();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog got timeout exp completion");
        $fatal(1);
    end

endmodule
